// File: rtl/mux_rr_arbiter_pkg.sv
// Shared types and sizing helpers for the round-robin mux arbiter.
package mux_rr_arbiter_pkg;

  localparam int N_DEF  = 8;
  localparam int DW_DEF = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  // Select width; a 1-bit floor keeps degenerate sizes legal.
  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mux_rr_arbiter_pick.sv
// Combinational round-robin picker: first set request at or after start_i,
// wrapping modulo N, via a double-width rotate and priority encode.
module rr_pick
  import mux_rr_arbiter_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int SW = sel_w(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [SW-1:0] start_i,
  output logic          found_o,
  output logic [SW-1:0] idx_o
);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [SW-1:0]  off;

  always_comb begin
    dbl     = {req_i, req_i} >> start_i;
    rot     = dbl[N-1:0];
    found_o = |rot;
    off     = '0;
    // Descending scan so the lowest rotated position wins.
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) off = SW'(i);
    end
    // N is a power of two, so the add wraps modulo N for free.
    idx_o = start_i + off;
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter steering one of N data words onto a valid/ready port.
// Optional burst lock: define MUX_RR_ARBITER_LOCK_EN to add the lock input.
module mux_rr_arbiter
  import mux_rr_arbiter_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int DW = DW_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req,
  input  logic [N*DW-1:0]      data_in,
`ifdef MUX_RR_ARBITER_LOCK_EN
  input  logic [N-1:0]         lock,
`endif
  output logic [N-1:0]         gnt,
  output logic [sel_w(N)-1:0]  sel,
  output logic                 out_valid,
  output logic [DW-1:0]        out_data,
  input  logic                 out_ready
);

  localparam int SW = sel_w(N);
  localparam logic [N-1:0] ONE = N'(1);

  state_e        state_q;
  logic [SW-1:0] sel_q;
  logic [SW-1:0] last_q;
  logic [N-1:0]  gnt_q;

  logic [SW-1:0] pick_start;
  logic          pick_found;
  logic [SW-1:0] pick_idx;
  logic          xfer;
  logic          locked;
  logic          rearb;

  assign out_valid = (state_q == GRANT) && req[sel_q];
  assign out_data  = out_valid ? data_in[sel_q*DW +: DW] : '0;
  assign gnt       = gnt_q;
  assign sel       = sel_q;
  assign xfer      = out_valid && out_ready;

`ifdef MUX_RR_ARBITER_LOCK_EN
  assign locked = lock[sel_q] && req[sel_q];
`else
  assign locked = 1'b0;
`endif

  // Abandon (req[sel] dropped) re-arbitrates like a transfer, without moving last.
  assign rearb      = (xfer && !locked) || ((state_q == GRANT) && !req[sel_q]);
  assign pick_start = (state_q == IDLE) ? last_q + 1'b1 : sel_q + 1'b1;

  rr_pick #(.N(N), .SW(SW)) u_pick (
    .req_i   (req),
    .start_i (pick_start),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      gnt_q   <= '0;
      last_q  <= SW'(N - 1);
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_found) begin
            state_q <= GRANT;
            sel_q   <= pick_idx;
            gnt_q   <= ONE << pick_idx;
          end
        end
        GRANT: begin
          if (rearb) begin
            if (xfer) last_q <= sel_q;
            if (pick_found) begin
              sel_q <= pick_idx;
              gnt_q <= ONE << pick_idx;
            end else begin
              state_q <= IDLE;
              gnt_q   <= '0;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Randomized self-checking bench for mux_rr_arbiter with a behavioural model
// plus directed literal scenarios; honours MUX_RR_ARBITER_LOCK_EN.
module tb_mux_rr_arbiter;
  localparam int N  = 8;
  localparam int DW = 8;
  localparam int SW = 3;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    req;
  logic [N*DW-1:0] data_in;
  logic [N-1:0]    lock;
  logic [N-1:0]    gnt;
  logic [SW-1:0]   sel;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic            out_ready;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  mux_rr_arbiter #(.N(N), .DW(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .data_in   (data_in),
`ifdef MUX_RR_ARBITER_LOCK_EN
    .lock      (lock),
`endif
    .gnt       (gnt),
    .sel       (sel),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Model: who holds the grant, and the pointer of the last completed transfer.
  bit  m_gr;
  int  m_sel;
  int  m_last;
  logic [N-1:0] lock_v;

`ifdef MUX_RR_ARBITER_LOCK_EN
  assign lock_v = lock;
`else
  assign lock_v = '0;
`endif

  function automatic int winner(input logic [N-1:0] r, input int from);
    for (int k = 0; k < N; k++)
      if (r[(from + k) % N]) return (from + k) % N;
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin : mdl
    int w;
    if (!rst_n) begin
      m_gr   <= 1'b0;
      m_sel  <= 0;
      m_last <= N - 1;
    end else if (!m_gr) begin
      w = winner(req, (m_last + 1) % N);
      if (w >= 0) begin
        m_gr  <= 1'b1;
        m_sel <= w;
      end
    end else if (req[m_sel] && !out_ready) begin
      m_gr <= m_gr;
    end else if (req[m_sel] && lock_v[m_sel]) begin
      m_gr <= m_gr;
    end else begin
      if (req[m_sel]) m_last <= m_sel;
      w = winner(req, (m_sel + 1) % N);
      if (w < 0) m_gr <= 1'b0;
      else       m_sel <= w;
    end
  end

  always @(negedge clk) begin : cmp
    logic          ev;
    logic [N-1:0]  eg;
    logic [DW-1:0] ed;
    if (rst_n) begin
      ev = m_gr && req[m_sel];
      eg = m_gr ? (N'(1) << m_sel) : '0;
      ed = ev ? data_in[m_sel*DW +: DW] : '0;
      chk("m_gnt", 32'(gnt), 32'(eg));
      chk("m_sel", 32'(sel), 32'(m_sel));
      chk("m_valid", 32'(out_valid), 32'(ev));
      chk("m_data", 32'(out_data), 32'(ed));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge; completes before the next falling edge.
  task automatic do_reset();
    rst_n = 1'b0;
    req = '0;
    out_ready = 1'b0;
    lock = '0;
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] r;
    rst_n = 1'b0; req = '0; data_in = '0; out_ready = 1'b0; lock = '0;
    #12;
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_sel", 32'(sel), 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_data", 32'(out_data), 0);
    rst_n = 1'b1;

    // Lone requester 0: one-cycle latency, then repeats every cycle.
    req = 8'h01; data_in = 64'h0000_0000_0000_00A5; out_ready = 1'b1;
    tick();
    chk("t1_gnt", 32'(gnt), 32'h01);
    chk("t1_sel", 32'(sel), 0);
    chk("t1_valid", 32'(out_valid), 1);
    chk("t1_data", 32'(out_data), 32'hA5);
    tick();
    chk("t1_repeat", 32'(sel), 0);

    // All requesting: strict rotation with no bubbles.
    do_reset();
    req = 8'hFF; out_ready = 1'b1; data_in = {$urandom, $urandom};
    for (int k = 0; k < 9; k++) begin
      tick();
      chk("t2_sel", 32'(sel), 32'(k % 8));
      chk("t2_data", 32'(out_data), 32'(data_in[(k % 8)*DW +: DW]));
    end

    // Stall holds sel=0 for five cycles, then 7, then 0.
    do_reset();
    req = 8'h81; out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t3_stall_sel", 32'(sel), 0);
      chk("t3_stall_valid", 32'(out_valid), 1);
    end
    out_ready = 1'b1;
    tick();
    chk("t3_next", 32'(sel), 7);
    tick();
    chk("t3_wrap", 32'(sel), 0);

    // Abandon: valid drops at once, idle next, pointer unchanged.
    do_reset();
    req = 8'h08;
    tick();
    chk("t4_sel", 32'(sel), 3);
    chk("t4_gnt", 32'(gnt), 32'h08);
    req = 8'h00;
    #1;
    chk("t4_drop", 32'(out_valid), 0);
    tick();
    chk("t4_idle", 32'(gnt), 0);
    req = 8'hFF;
    tick();
    chk("t4_ptr", 32'(sel), 0);

    // Asynchronous reset mid-grant, then restart from pointer N-1.
    do_reset();
    req = 8'hFF; out_ready = 1'b1;
    tick();
    #1;
    rst_n = 1'b0;
    #1;
    chk("t5_gnt", 32'(gnt), 0);
    chk("t5_valid", 32'(out_valid), 0);
    chk("t5_data", 32'(out_data), 0);
    req = 8'h30;
    rst_n = 1'b1;
    tick();
    chk("t5_sel", 32'(sel), 4);
    chk("t5_gnt2", 32'(gnt), 32'h10);

`ifdef MUX_RR_ARBITER_LOCK_EN
    do_reset();
    req = 8'h06; lock = 8'h02; out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("lk_hold", 32'(sel), 1);
    end
    lock = '0;
    tick();
    chk("lk_release", 32'(sel), 2);
`endif

    // Random traffic; the compare process checks every cycle.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      tick();
      if ($urandom_range(0, 299) == 0) do_reset();
      r = $urandom;
      if ($urandom_range(0, 1) == 0) begin
        case ($urandom_range(0, 2))
          0:       req = r[7:0] & r[15:8];
          1:       req = r[7:0];
          default: req = N'(1) << r[18:16];
        endcase
      end
      out_ready = ($urandom_range(0, 3) != 0);
      data_in   = {$urandom, $urandom};
`ifdef MUX_RR_ARBITER_LOCK_EN
      lock = r[31:24] & r[23:16];
`endif
    end

    tick();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
